// File: rtl/data_ctrl_pkg.sv
// data_ctrl_pkg
//   Constants and types shared by the data-memory controller and its
//   extension sub-module.
//   - Width codes (one-hot), matching the encoding used by the load buffer.
//   - Controller state encoding.
//   - width_bytes(): maps a width code to its byte count (illegal -> 1).
package data_ctrl_pkg;

  localparam logic [2:0] W_BYTE = 3'b001;
  localparam logic [2:0] W_HALF = 3'b010;
  localparam logic [2:0] W_WORD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Byte count for a width code; anything that is not half or word is a byte.
  function automatic logic [2:0] width_bytes(input logic [2:0] width);
    logic [2:0] n;
    case (width)
      W_HALF:  n = 3'd2;
      W_WORD:  n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_ctrl_extend.sv
// data_ctrl_extend
//   Combinational zero/sign extension of an assembled little-endian load.
//   Ports:
//     bytes_i  [DATA_WIDTH]  assembled bytes, byte 0 in bits [7:0]
//     width_i  [3]           width code (001 byte, 010 half, 100 word;
//                            any other code behaves as byte)
//     sgn_i    [1]           1 = sign-extend, 0 = zero-fill (ignored for word)
//     data_o   [DATA_WIDTH]  extended result
module data_ctrl_extend
  import data_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] bytes_i,
  input  logic [2:0]            width_i,
  input  logic                  sgn_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Replicate the top valid bit (or zero) above the loaded bytes.
  always_comb begin
    data_o = '0;
    case (width_i)
      W_HALF:  data_o = {{(DATA_WIDTH-16){sgn_i & bytes_i[15]}}, bytes_i[15:0]};
      W_WORD:  data_o = bytes_i;
      default: data_o = {{(DATA_WIDTH-8){sgn_i & bytes_i[7]}}, bytes_i[7:0]};
    endcase
  end

endmodule

// File: rtl/data_ctrl.sv
// data_ctrl
//   Data-memory controller between the load/store buffers and a single
//   8-bit RAM port. Each request is serialised into little-endian byte
//   accesses; stores take priority over loads because they are committed.
//   Ports:
//     clk_in, rst_in (async, active-high), rdy_in (global enable)
//     rob_datactrl_rst_in          flush: drops pending/in-flight loads
//     lbuffer_datactrl_*_in        load request (en, addr, width, sgn)
//     datactrl_lbuffer_en_out/data_out   load-done pulse and extended data
//     sbuffer_datactrl_*_in        store request (en, addr, width, data)
//     datactrl_sbuffer_en_out      store-done pulse
//     mem_din_in / mem_dout_out / mem_a_out / mem_wr_out   RAM port
//   RAM read data for the address driven in cycle c arrives in cycle c+1.
module data_ctrl
  import data_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_datactrl_rst_in,
  input  logic                  lbuffer_datactrl_en_in,
  input  logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]            lbuffer_datactrl_width_in,
  input  logic                  lbuffer_datactrl_sgn_in,
  output logic                  datactrl_lbuffer_en_out,
  output logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_out,
  input  logic                  sbuffer_datactrl_en_in,
  input  logic [ADDR_WIDTH-1:0] sbuffer_datactrl_addr_in,
  input  logic [2:0]            sbuffer_datactrl_width_in,
  input  logic [DATA_WIDTH-1:0] sbuffer_datactrl_data_in,
  output logic                  datactrl_sbuffer_en_out,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out
);

  // Controller state
  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            width_q, width_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;

  // Output registers
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  ld_en_q, ld_en_d;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
  logic                  st_en_q, st_en_d;

  // Pending request latches
  logic                  ld_full_q, ld_full_d;
  logic [ADDR_WIDTH-1:0] ld_addr_q, ld_addr_d;
  logic [2:0]            ld_width_q, ld_width_d;
  logic                  ld_sgn_q, ld_sgn_d;
  logic                  st_full_q, st_full_d;
  logic [ADDR_WIDTH-1:0] st_addr_q, st_addr_d;
  logic [2:0]            st_width_q, st_width_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;

  // Combinational helpers
  logic [DATA_WIDTH-1:0] asm_full_s;
  logic [DATA_WIDTH-1:0] ext_s;
  logic [7:0]            next_wbyte_s;

  // A same-cycle strobe is as good as a full latch (the latch is empty then).
  logic                  st_avail_s;
  logic [ADDR_WIDTH-1:0] st_addr_s;
  logic [2:0]            st_width_s;
  logic [DATA_WIDTH-1:0] st_data_s;
  logic                  ld_avail_s;
  logic [ADDR_WIDTH-1:0] ld_addr_s;
  logic [2:0]            ld_width_s;
  logic                  ld_sgn_s;

  assign st_avail_s = st_full_q | sbuffer_datactrl_en_in;
  assign st_addr_s  = sbuffer_datactrl_en_in ? sbuffer_datactrl_addr_in  : st_addr_q;
  assign st_width_s = sbuffer_datactrl_en_in ? sbuffer_datactrl_width_in : st_width_q;
  assign st_data_s  = sbuffer_datactrl_en_in ? sbuffer_datactrl_data_in  : st_data_q;
  assign ld_avail_s = ~rob_datactrl_rst_in & (ld_full_q | lbuffer_datactrl_en_in);
  assign ld_addr_s  = lbuffer_datactrl_en_in ? lbuffer_datactrl_addr_in  : ld_addr_q;
  assign ld_width_s = lbuffer_datactrl_en_in ? lbuffer_datactrl_width_in : ld_width_q;
  assign ld_sgn_s   = lbuffer_datactrl_en_in ? lbuffer_datactrl_sgn_in   : ld_sgn_q;

  // Merge the byte on mem_din_in into the assembly: with counter value c,
  // the byte on the bus is byte c-1 (address driven two edges earlier).
  always_comb begin
    asm_full_s = asm_q;
    case (cnt_q)
      3'd1:    asm_full_s[7:0]   = mem_din_in;
      3'd2:    asm_full_s[15:8]  = mem_din_in;
      3'd3:    asm_full_s[23:16] = mem_din_in;
      3'd4:    asm_full_s[31:24] = mem_din_in;
      default: asm_full_s = asm_q;
    endcase
  end

  // Store byte for the next write beat (byte index cnt+1).
  always_comb begin
    next_wbyte_s = wdata_q[7:0];
    case (cnt_q)
      3'd0:    next_wbyte_s = wdata_q[15:8];
      3'd1:    next_wbyte_s = wdata_q[23:16];
      3'd2:    next_wbyte_s = wdata_q[31:24];
      default: next_wbyte_s = wdata_q[7:0];
    endcase
  end

  data_ctrl_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extend (
    .bytes_i (asm_full_s),
    .width_i (width_q),
    .sgn_i   (sgn_q),
    .data_o  (ext_s)
  );

  // Next-state logic: latch capture, request selection and byte sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    width_d    = width_q;
    sgn_d      = sgn_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    ld_en_d    = 1'b0;
    ld_data_d  = ld_data_q;
    st_en_d    = 1'b0;
    ld_full_d  = ld_full_q;
    ld_addr_d  = ld_addr_q;
    ld_width_d = ld_width_q;
    ld_sgn_d   = ld_sgn_q;
    st_full_d  = st_full_q;
    st_addr_d  = st_addr_q;
    st_width_d = st_width_q;
    st_data_d  = st_data_q;

    if (lbuffer_datactrl_en_in) begin
      ld_full_d  = 1'b1;
      ld_addr_d  = lbuffer_datactrl_addr_in;
      ld_width_d = lbuffer_datactrl_width_in;
      ld_sgn_d   = lbuffer_datactrl_sgn_in;
    end
    // A flush also discards a load strobe arriving in the same cycle.
    if (rob_datactrl_rst_in) begin
      ld_full_d = 1'b0;
    end
    if (sbuffer_datactrl_en_in) begin
      st_full_d  = 1'b1;
      st_addr_d  = sbuffer_datactrl_addr_in;
      st_width_d = sbuffer_datactrl_width_in;
      st_data_d  = sbuffer_datactrl_data_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (st_avail_s) begin
          state_d    = ST_WRITE;
          st_full_d  = 1'b0;
          cnt_d      = 3'd0;
          nbytes_d   = width_bytes(st_width_s);
          wdata_d    = st_data_s;
          mem_a_d    = st_addr_s;
          mem_dout_d = st_data_s[7:0];
          mem_wr_d   = 1'b1;
        end else if (ld_avail_s) begin
          state_d   = ST_READ;
          ld_full_d = 1'b0;
          cnt_d     = 3'd0;
          nbytes_d  = width_bytes(ld_width_s);
          width_d   = ld_width_s;
          sgn_d     = ld_sgn_s;
          asm_d     = '0;
          mem_a_d   = ld_addr_s;
          mem_wr_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        if (rob_datactrl_rst_in) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          asm_d = asm_full_s;
          if (cnt_q == nbytes_q) begin
            // Last byte is on the bus now: extend straight from the merge.
            ld_en_d   = 1'b1;
            ld_data_d = ext_s;
            state_d   = ST_IDLE;
          end else if ((cnt_q + 3'd1) < nbytes_q) begin
            mem_a_d = mem_a_q + ADDR_WIDTH'(1);
          end else begin
            mem_a_d = mem_a_q;
          end
        end
      end

      ST_WRITE: begin
        if ((cnt_q + 3'd1) == nbytes_q) begin
          st_en_d  = 1'b1;
          mem_wr_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_a_d    = mem_a_q + ADDR_WIDTH'(1);
          mem_dout_d = next_wbyte_s;
          mem_wr_d   = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State, latch and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      width_q    <= 3'd0;
      sgn_q      <= 1'b0;
      wdata_q    <= '0;
      asm_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      ld_en_q    <= 1'b0;
      ld_data_q  <= '0;
      st_en_q    <= 1'b0;
      ld_full_q  <= 1'b0;
      ld_addr_q  <= '0;
      ld_width_q <= 3'd0;
      ld_sgn_q   <= 1'b0;
      st_full_q  <= 1'b0;
      st_addr_q  <= '0;
      st_width_q <= 3'd0;
      st_data_q  <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      width_q    <= width_d;
      sgn_q      <= sgn_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      ld_en_q    <= ld_en_d;
      ld_data_q  <= ld_data_d;
      st_en_q    <= st_en_d;
      ld_full_q  <= ld_full_d;
      ld_addr_q  <= ld_addr_d;
      ld_width_q <= ld_width_d;
      ld_sgn_q   <= ld_sgn_d;
      st_full_q  <= st_full_d;
      st_addr_q  <= st_addr_d;
      st_width_q <= st_width_d;
      st_data_q  <= st_data_d;
    end
  end

  assign datactrl_lbuffer_en_out   = ld_en_q;
  assign datactrl_lbuffer_data_out = ld_data_q;
  assign datactrl_sbuffer_en_out   = st_en_q;
  assign mem_a_out                 = mem_a_q;
  assign mem_dout_out              = mem_dout_q;
  assign mem_wr_out                = mem_wr_q;

endmodule

// File: tb/tb_data_ctrl.sv
// tb_data_ctrl
//   Directed bench for data_ctrl with a byte RAM model (read data one
//   cycle after the address; the RAM port shares the global enable).
module tb_data_ctrl;
  import data_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        lb_en;
  logic [31:0] lb_addr;
  logic [2:0]  lb_width;
  logic        lb_sgn;
  logic        ld_en;
  logic [31:0] ld_data;
  logic        sb_en;
  logic [31:0] sb_addr;
  logic [2:0]  sb_width;
  logic [31:0] sb_data;
  logic        st_en;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:65535];

  int n_assert = 0;
  int n_fail   = 0;
  int ld_cnt, st_cnt, ld_at, st_at;

  data_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_in                    (clk),
    .rst_in                    (rst),
    .rdy_in                    (rdy),
    .rob_datactrl_rst_in       (flush),
    .lbuffer_datactrl_en_in    (lb_en),
    .lbuffer_datactrl_addr_in  (lb_addr),
    .lbuffer_datactrl_width_in (lb_width),
    .lbuffer_datactrl_sgn_in   (lb_sgn),
    .datactrl_lbuffer_en_out   (ld_en),
    .datactrl_lbuffer_data_out (ld_data),
    .sbuffer_datactrl_en_in    (sb_en),
    .sbuffer_datactrl_addr_in  (sb_addr),
    .sbuffer_datactrl_width_in (sb_width),
    .sbuffer_datactrl_data_in  (sb_data),
    .datactrl_sbuffer_en_out   (st_en),
    .mem_din_in                (mem_din),
    .mem_dout_out              (mem_dout),
    .mem_a_out                 (mem_a),
    .mem_wr_out                (mem_wr)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Strobe a load for one cycle; returns just after the accepting edge.
  task automatic load(input logic [31:0] a, input logic [2:0] w, input logic s);
    lb_addr = a; lb_width = w; lb_sgn = s; lb_en = 1'b1;
    tick();
    lb_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
    sb_addr = a; sb_width = w; sb_data = d; sb_en = 1'b1;
    tick();
    sb_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h78; ram[16'h1001] = 8'h56;
    ram[16'h1002] = 8'h34; ram[16'h1003] = 8'h12;
    ram[16'h3000] = 8'h80;
    ram[16'h3010] = 8'h00; ram[16'h3011] = 8'h80;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    lb_en = 1'b0; lb_addr = 32'd0; lb_width = 3'd0; lb_sgn = 1'b0;
    sb_en = 1'b0; sb_addr = 32'd0; sb_width = 3'd0; sb_data = 32'd0;
    #2;
    check("rst_ld_en", {31'd0, ld_en}, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_st_en", {31'd0, st_en}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // LW at 0x1000
    load(32'h1000, W_WORD, 1'b0);
    check("lw_a0", mem_a, 32'h1000);
    check("lw_wr0", {31'd0, mem_wr}, 32'd0);
    tick(); check("lw_a1", mem_a, 32'h1001);
    tick(); check("lw_a2", mem_a, 32'h1002);
    tick(); check("lw_a3", mem_a, 32'h1003);
    check("lw_wr3", {31'd0, mem_wr}, 32'd0);
    tick(); check("lw_en4", {31'd0, ld_en}, 32'd0);
    tick(); check("lw_en5", {31'd0, ld_en}, 32'd1);
    check("lw_data", ld_data, 32'h1234_5678);
    tick(); check("lw_en6", {31'd0, ld_en}, 32'd0);
    check("lw_hold", ld_data, 32'h1234_5678);

    // LB signed / LBU / LH signed
    load(32'h3000, W_BYTE, 1'b1);
    tick(); check("lb_en1", {31'd0, ld_en}, 32'd0);
    tick(); check("lb_en2", {31'd0, ld_en}, 32'd1);
    check("lb_data", ld_data, 32'hFFFF_FF80);
    tick();
    load(32'h3000, W_BYTE, 1'b0);
    tick(); tick(); check("lbu_en2", {31'd0, ld_en}, 32'd1);
    check("lbu_data", ld_data, 32'h0000_0080);
    tick();
    load(32'h3010, W_HALF, 1'b1);
    tick(); tick(); check("lh_en2", {31'd0, ld_en}, 32'd0);
    tick(); check("lh_en3", {31'd0, ld_en}, 32'd1);
    check("lh_data", ld_data, 32'hFFFF_8000);
    tick();
    // Illegal width behaves as a byte
    load(32'h3000, 3'b011, 1'b1);
    tick(); tick(); check("ill_en2", {31'd0, ld_en}, 32'd1);
    check("ill_data", ld_data, 32'hFFFF_FF80);
    tick();

    // SH 0xAABBCCDD at 0x2002
    store(32'h2002, W_HALF, 32'hAABB_CCDD);
    check("sh_a0", mem_a, 32'h2002);
    check("sh_d0", {24'd0, mem_dout}, 32'h0000_00DD);
    check("sh_wr0", {31'd0, mem_wr}, 32'd1);
    tick();
    check("sh_a1", mem_a, 32'h2003);
    check("sh_d1", {24'd0, mem_dout}, 32'h0000_00CC);
    check("sh_wr1", {31'd0, mem_wr}, 32'd1);
    check("sh_st1", {31'd0, st_en}, 32'd0);
    tick();
    check("sh_st2", {31'd0, st_en}, 32'd1);
    check("sh_wr2", {31'd0, mem_wr}, 32'd0);
    tick();
    check("sh_st3", {31'd0, st_en}, 32'd0);
    check("sh_wr3", {31'd0, mem_wr}, 32'd0);
    check("sh_ram2", {24'd0, ram[16'h2002]}, 32'h0000_00DD);
    check("sh_ram3", {24'd0, ram[16'h2003]}, 32'h0000_00CC);

    // Simultaneous SW and LW to the same word: store first, load sees it
    sb_addr = 32'h4000; sb_width = W_WORD; sb_data = 32'h1122_3344; sb_en = 1'b1;
    lb_addr = 32'h4000; lb_width = W_WORD; lb_sgn = 1'b0; lb_en = 1'b1;
    tick();
    sb_en = 1'b0; lb_en = 1'b0;
    check("both_wr0", {31'd0, mem_wr}, 32'd1);
    ld_cnt = 0; st_cnt = 0; ld_at = 0; st_at = 0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (st_en) begin st_cnt++; st_at = c; end
      if (ld_en) begin ld_cnt++; ld_at = c; check("both_data", ld_data, 32'h1122_3344); end
    end
    check("both_st_cnt", st_cnt, 32'd1);
    check("both_st_at", st_at, 32'd4);
    check("both_ld_cnt", ld_cnt, 32'd1);
    check("both_ld_at", ld_at, 32'd10);
    check("both_wr_end", {31'd0, mem_wr}, 32'd0);

    // Flush in the third cycle of an LW
    load(32'h1000, W_WORD, 1'b0);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    check("fl_wr", {31'd0, mem_wr}, 32'd0);
    ld_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (ld_en) ld_cnt++;
      tick();
    end
    check("fl_no_pulse", ld_cnt, 32'd0);
    load(32'h3000, W_BYTE, 1'b0);
    tick(); tick();
    check("fl_lb_en", {31'd0, ld_en}, 32'd1);
    check("fl_lb_data", ld_data, 32'h0000_0080);
    tick();

    // rdy_in low for 3 cycles mid-READ
    load(32'h1000, W_WORD, 1'b0);
    tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    check("stall_a", mem_a, 32'h1001);
    rdy = 1'b1;
    tick(); tick(); tick();
    check("stall_en7", {31'd0, ld_en}, 32'd0);
    tick();
    check("stall_en8", {31'd0, ld_en}, 32'd1);
    check("stall_data", ld_data, 32'h1234_5678);
    tick();

    // Async reset mid-WRITE, between edges
    store(32'h5000, W_WORD, 32'hDEAD_BEEF);
    tick();
    check("ar_pre_wr", {31'd0, mem_wr}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_wr", {31'd0, mem_wr}, 32'd0);
    check("ar_a", mem_a, 32'd0);
    check("ar_dout", {24'd0, mem_dout}, 32'd0);
    check("ar_ld_data", ld_data, 32'd0);
    check("ar_ld_en", {31'd0, ld_en}, 32'd0);
    check("ar_st_en", {31'd0, st_en}, 32'd0);
    check("ar_latches", {30'd0, dut.ld_full_q, dut.st_full_q}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
